// File: rtl/pll_cfg_pkg.sv
// Shared types and the preset table for the PLL reconfiguration sequencer.
// PLL_CFG_READBACK_EN adds the VERIFY state to the FSM encoding.
package pll_cfg_pkg;

    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_N     = 6'd3;
    localparam logic [5:0] REG_M     = 6'd4;
    localparam logic [5:0] REG_C     = 6'd5;
    localparam logic [5:0] REG_BW    = 6'd8;
    localparam logic [5:0] REG_CP    = 6'd9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MODE,
        ST_FETCH,
        ST_LOAD,
`ifdef PLL_CFG_READBACK_EN
        ST_VERIFY,
`endif
        ST_START,
        ST_SETTLE,
        ST_LOCKW,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        last;
        logic [5:0]  addr;
        logic [31:0] data;
    } cfg_entry_t;

    localparam int unsigned ENTRY_W = $bits(cfg_entry_t);

    localparam cfg_entry_t END_ENTRY = '{last: 1'b1, addr: REG_MODE, data: 32'h0};

    // Preset 0: 100/50 MHz from a 300 MHz VCO (N bypassed, C index in [22:18])
    localparam cfg_entry_t PRESET0 [4] = '{
        '{last: 1'b0, addr: REG_N, data: 32'h0001_0000},
        '{last: 1'b0, addr: REG_M, data: 32'h0000_0303},
        '{last: 1'b0, addr: REG_C, data: 32'h0002_0201},
        '{last: 1'b1, addr: REG_C, data: 32'h0004_0303}
    };

    // Preset 1: 75/37.5 MHz
    localparam cfg_entry_t PRESET1 [2] = '{
        '{last: 1'b0, addr: REG_C, data: 32'h0000_0202},
        '{last: 1'b1, addr: REG_C, data: 32'h0004_0404}
    };

    // Presets other than 1 fall back to preset 0's contents.
    function automatic cfg_entry_t cfg_lookup(input logic [7:0] preset, input logic [7:0] index);
        cfg_entry_t e;
        e = END_ENTRY;
        if (preset == 8'd1) begin
            if (index < 8'd2) e = PRESET1[index[0]];
        end else begin
            if (index < 8'd4) e = PRESET0[index[1:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/pll_cfg_rom.sv
// Registered preset table lookup: (preset, index) -> packed cfg entry, 1-cycle latency.
module pll_cfg_rom
    import pll_cfg_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int IDX_W = 3
) (
    input  logic               clk,
    input  logic [SEL_W-1:0]   preset,
    input  logic [IDX_W-1:0]   index,
    output logic [ENTRY_W-1:0] entry
);

    always_ff @(posedge clk) begin
        entry <= cfg_lookup(8'(preset), 8'(index));
    end

endmodule

// File: rtl/pll_cfg_sequencer.sv
// Avalon-MM master replaying a PLL counter preset into the reconfig controller, then awaiting lock.
// Optional PLL_CFG_READBACK_EN: read back and verify every LOAD write before moving on.
module pll_cfg_sequencer
    import pll_cfg_pkg::*;
#(
    parameter int NUM_PRESETS  = 4,
    parameter int MAX_WORDS    = 8,
    parameter int LOCK_DLY     = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_req,
    input  logic [$clog2(NUM_PRESETS)-1:0] cfg_sel,
    output logic [5:0]                     mgmt_address,
    output logic                           mgmt_write,
    output logic                           mgmt_read,
    output logic [31:0]                    mgmt_writedata,
    input  logic [31:0]                    mgmt_readdata,
    input  logic                           mgmt_waitrequest,
    input  logic                           pll_locked,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    localparam int SEL_W   = $clog2(NUM_PRESETS);
    localparam int IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int CNT_MAX = (LOCK_DLY > LOCK_TIMEOUT) ? LOCK_DLY : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [5:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [ENTRY_W-1:0] rom_bits;
    cfg_entry_t         rom_q;
    logic               last_word;

    pll_cfg_rom #(
        .SEL_W (SEL_W),
        .IDX_W (IDX_W)
    ) u_rom (
        .clk    (clk),
        .preset (sel_q),
        .index  (index_q),
        .entry  (rom_bits)
    );

    assign rom_q     = cfg_entry_t'(rom_bits);
    assign last_word = rom_q.last || (index_q == IDX_W'(MAX_WORDS - 1));

`ifdef PLL_CFG_READBACK_EN
    logic rd_q, rd_d;
    assign mgmt_read = rd_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^mgmt_readdata;
    assign mgmt_read       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            index_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef PLL_CFG_READBACK_EN
            rd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef PLL_CFG_READBACK_EN
            rd_q    <= rd_d;
`endif
        end
    end

    // Strobes are issued from a registered 0 cycle, which also guarantees the idle gap between transfers.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        error_d = error_q;
`ifdef PLL_CFG_READBACK_EN
        rd_d    = rd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    sel_d   = ({1'b0, cfg_sel} < (SEL_W + 1)'(NUM_PRESETS)) ? cfg_sel : '0;
                    index_d = '0;
                    error_d = 1'b0;
                    state_d = ST_MODE;
                end
            end
            ST_MODE: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    addr_d  = REG_MODE;
                    wdata_d = '0;
                end else if (!mgmt_waitrequest) begin
                    wr_d    = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    addr_d  = rom_q.addr;
                    wdata_d = rom_q.data;
                end else if (!mgmt_waitrequest) begin
                    wr_d = 1'b0;
`ifdef PLL_CFG_READBACK_EN
                    state_d = ST_VERIFY;
`else
                    if (last_word) begin
                        state_d = ST_START;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
`endif
                end
            end
`ifdef PLL_CFG_READBACK_EN
            ST_VERIFY: begin
                if (!rd_q) begin
                    rd_d = 1'b1;
                end else if (!mgmt_waitrequest) begin
                    rd_d = 1'b0;
                    if (mgmt_readdata[17:0] != rom_q.data[17:0]) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (last_word) begin
                        state_d = ST_START;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
`endif
            ST_START: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    addr_d  = REG_START;
                    wdata_d = 32'd1;
                end else if (!mgmt_waitrequest) begin
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(LOCK_DLY - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LOCKW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKW: begin
                if (pll_locked) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mgmt_address   = addr_q;
    assign mgmt_write     = wr_q;
    assign mgmt_writedata = wdata_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Scoreboard bench for pll_cfg_sequencer; expected write sequences are queued at request time.
// Define PLL_CFG_READBACK_EN for both RTL and bench to exercise the readback path.
module tb_pll_cfg_sequencer;

    localparam int D = 16;
    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [1:0]  cfg_sel;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    logic start_seen = 1'b0;
    logic err_at_done = 1'b0;
    logic busy_at_done = 1'b0;
    logic corrupt = 1'b0;
    logic [31:0] last_wdata = '0;
    logic [37:0] exp_q[$];

    pll_cfg_sequencer #(
        .NUM_PRESETS  (4),
        .MAX_WORDS    (8),
        .LOCK_DLY     (D),
        .LOCK_TIMEOUT (T)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_req          (cfg_req),
        .cfg_sel          (cfg_sel),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: reads return the last written word, optionally corrupted on preset 0's C0 word.
    assign mgmt_readdata = (corrupt && last_wdata == 32'h0002_0201) ? (last_wdata ^ 32'h1) : last_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_preset(input int p);
        push_wr(6'd0, 32'd0);
        if (p == 1) begin
            push_wr(6'd5, 32'h0000_0202);
            push_wr(6'd5, 32'h0004_0404);
        end else begin
            push_wr(6'd3, 32'h0001_0000);
            push_wr(6'd4, 32'h0000_0303);
            push_wr(6'd5, 32'h0002_0201);
            push_wr(6'd5, 32'h0004_0303);
        end
        push_wr(6'd2, 32'd1);
    endtask

    task automatic request(input logic [1:0] sel);
        start_seen = 1'b0;
        @(posedge clk); #1;
        cfg_req = 1'b1;
        cfg_sel = sel;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("error_after_accept", 32'(error), 32'd0);
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget && !start_seen; i++) begin
            @(posedge clk); #1;
        end
        check("start_write_seen", 32'(start_seen), 32'd1);
    endtask

    task automatic wait_done(input int cnt0, input int budget);
        for (int i = 0; i < budget && done_cnt == cnt0; i++) begin
            @(posedge clk); #1;
        end
        check("done_count", 32'(done_cnt - cnt0), 32'd1);
    endtask

    task automatic wait_write_addr(input logic [5:0] a, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            found = mgmt_write && (mgmt_address == a);
        end
        check("write_addr_seen", 32'(found), 32'd1);
    endtask

    // Monitor: sampled mid-cycle, after the bench's negedge drives have settled.
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk); #1;
            if (prev_stall) begin
                check("hold_write", 32'(mgmt_write), 32'd1);
                check("hold_addr", 32'(mgmt_address), 32'(prev_addr));
                check("hold_data", mgmt_writedata, prev_data);
            end
            prev_stall = mgmt_write && mgmt_waitrequest && !rst;
            prev_addr  = mgmt_address;
            prev_data  = mgmt_writedata;
            if (mgmt_write && !mgmt_waitrequest && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(mgmt_address), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mgmt_address), 32'(e[37:32]));
                    check("wr_data", mgmt_writedata, e[31:0]);
                end
                last_wdata = mgmt_writedata;
                if (mgmt_address == 6'd2) begin
                    start_seen = 1'b1;
                    start_cyc  = cyc + 1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                err_at_done  = error;
                busy_at_done = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt0;
        int target;
        rst = 1'b1;
        cfg_req = 1'b0;
        cfg_sel = '0;
        mgmt_waitrequest = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_write", 32'(mgmt_write), 32'd0);
        check("rst_read", 32'(mgmt_read), 32'd0);
        check("rst_addr", 32'(mgmt_address), 32'd0);
        check("rst_wdata", mgmt_writedata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;

        // 1: preset 1, no stalls, lock raised in the 5th LOCKW cycle
        cnt0 = done_cnt;
        push_preset(1);
        request(2'd1);
        wait_start(100);
        target = start_cyc + D + 4;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        pll_locked = 1'b1;
        wait_done(cnt0, 50);
        check("t1_done_time", 32'(done_cyc), 32'(start_cyc + D + 5));
        check("t1_error", 32'(err_at_done), 32'd0);
        check("t1_busy_at_done", 32'(busy_at_done), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: three-cycle stall on the M write of preset 0
        cnt0 = done_cnt;
        push_preset(0);
        request(2'd0);
        wait_write_addr(6'd4, 100);
        mgmt_waitrequest = 1'b1;
        repeat (3) @(negedge clk);
        mgmt_waitrequest = 1'b0;
        wait_done(cnt0, 200);
        check("t2_error", 32'(err_at_done), 32'd0);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: request during LOAD is ignored
        cnt0 = done_cnt;
        push_preset(1);
        request(2'd1);
        wait_write_addr(6'd5, 100);
        cfg_req = 1'b1;
        cfg_sel = 2'd2;
        @(negedge clk);
        cfg_req = 1'b0;
        wait_done(cnt0, 200);
        repeat (20) @(posedge clk);
        #1;
        check("t3_single_done", 32'(done_cnt - cnt0), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: lock never arrives, then a new request clears error
        pll_locked = 1'b0;
        cnt0 = done_cnt;
        push_preset(1);
        request(2'd1);
        wait_start(100);
        wait_done(cnt0, D + T + 50);
        check("t4_timeout_time", 32'(done_cyc), 32'(start_cyc + D + T));
        check("t4_error", 32'(err_at_done), 32'd1);
        @(posedge clk); #1;
        check("t4_error_sticky", 32'(error), 32'd1);
        pll_locked = 1'b1;
        cnt0 = done_cnt;
        push_preset(1);
        request(2'd1);
        wait_done(cnt0, 200);
        check("t4_rerun_error", 32'(err_at_done), 32'd0);

        // 5: reset while the M write is pending
        push_preset(0);
        request(2'd0);
        wait_write_addr(6'd4, 100);
        mgmt_waitrequest = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_write_dropped", 32'(mgmt_write), 32'd0);
        check("t5_read_dropped", 32'(mgmt_read), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        rst = 1'b0;
        mgmt_waitrequest = 1'b0;
        exp_q.delete();
        cnt0 = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_done", 32'(done_cnt - cnt0), 32'd0);
        push_preset(0);
        request(2'd0);
        wait_done(cnt0, 200);
        check("t5_rerun_error", 32'(err_at_done), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef PLL_CFG_READBACK_EN
        // 6: corrupted readback of C0 aborts before Start
        corrupt = 1'b1;
        cnt0 = done_cnt;
        push_wr(6'd0, 32'd0);
        push_wr(6'd3, 32'h0001_0000);
        push_wr(6'd4, 32'h0000_0303);
        push_wr(6'd5, 32'h0002_0201);
        request(2'd0);
        wait_done(cnt0, 200);
        check("t6_error", 32'(err_at_done), 32'd1);
        check("t6_no_start", 32'(start_seen), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        corrupt = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("final_idle", 32'(busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_cfg_sequencer.md
Name: pll_cfg_sequencer

Overview:
- Avalon-MM master that drives the PLL reconfiguration controller's management port. The controller in turn drives the 64-bit reconfig_to_pll bus of the reconfigurable Cyclone V PLL.
- On request, it replays one preset from a counter-setting table, issues Start, then waits for the PLL to relock.
- Sits between core-level clock-select logic (e.g. CPU turbo select) and the PLL reconfig controller.

Parameters:
NUM_PRESETS, 4, number of selectable presets
MAX_WORDS, 8, max register writes per preset (excluding mode and start)
LOCK_DLY, 16, cycles ignored after Start before locked is sampled
LOCK_TIMEOUT, 65535, cycles allowed for locked to assert after LOCK_DLY

Ports:
clk  in  1  system clock; same clock as the reconfig controller mgmt port
rst  in  1  synchronous active-high reset
cfg_req  in  1  single-cycle request pulse
cfg_sel  in  $clog2(NUM_PRESETS)  preset index, sampled on accepted cfg_req
mgmt_address  out  6  reconfig controller register address
mgmt_write  out  1  write strobe
mgmt_read  out  1  read strobe; stays 0 unless PLL_CFG_READBACK_EN
mgmt_writedata  out  32  write data
mgmt_readdata  in  32  read data, valid when mgmt_read=1 and mgmt_waitrequest=0
mgmt_waitrequest  in  1  controller stall
pll_locked  in  1  PLL locked, already synchronised to clk
busy  out  1  high from accept through DONE
done  out  1  one-cycle pulse at end of sequence, on success or failure
error  out  1  sticky failure flag; cleared on the next accepted request

Behaviour:
- Reset: all outputs 0; FSM=IDLE; sampled preset=0; index=0; counters=0.
- Reset mid-sequence drops mgmt_write/mgmt_read on the next edge with no completion. Software must re-request.
- Avalon rule: address, data and strobe are registered and held constant while mgmt_waitrequest=1. The transfer completes in the cycle where strobe=1 and waitrequest=0. The strobe deasserts at least one cycle between transfers.
- FSM states and transitions:
  - IDLE: busy=0. cfg_req=1 means accept: latch cfg_sel, clear error, index=0, go to MODE. cfg_req outside IDLE is ignored (no queueing).
  - MODE: write addr 0, data 0 (waitrequest mode). On completion go to FETCH.
  - FETCH: one cycle for the registered ROM read of entry (preset, index) = {last, addr[5:0], data[31:0]}.
  - LOAD: write addr/data. On completion: if last or index==MAX_WORDS-1, go to START; else index+1 and go to FETCH.
  - START: write addr 2, data 1. On completion go to SETTLE.
  - SETTLE: count LOCK_DLY cycles, then go to LOCKW.
  - LOCKW: pll_locked=1 gives done=1 and goes to DONE. Counter reaching LOCK_TIMEOUT gives error=1, done=1 and goes to DONE.
  - DONE: one cycle, busy=1, then IDLE.
- The earliest a new request can be accepted is the cycle after DONE.
- Latency with no waitrequest, N entries: 2 (MODE) + 3N (FETCH + LOAD + gap) + 2 (START) + LOCK_DLY + lock time + 1.
- ROM contents, register map 3=N, 4=M, 5=C (counter index in [22:18]), 8=bandwidth, 9=charge pump:
  - preset 0 = 100/50 MHz from a 300 MHz VCO: N bypass (addr 3 = 0x00010000), M (addr 4 = 0x00000303), C0 (addr 5 = 0x00020201), C1 (addr 5 = 0x00040303, last).
  - preset 1 = 75/37.5 MHz: C0 (addr 5 = 0x00000202), C1 (addr 5 = 0x00040404, last).
  - presets 2 and 3 are copies of preset 0.
- Selecting an index >= NUM_PRESETS selects preset 0.

Optional Feature:
- Macro PLL_CFG_READBACK_EN.
- With the macro: after each LOAD write completes, enter VERIFY. VERIFY issues a read of the same address (hold rule applies) and compares mgmt_readdata[17:0] with data[17:0].
  - Match: continue as for a LOAD completion.
  - Mismatch: set error, pulse done, skip Start, go to DONE.
- Without the macro: VERIFY does not exist, mgmt_read is tied 0, and mgmt_readdata is unused.

Decomposition:
- Package pll_cfg_pkg holds:
  - register address constants (MODE=0, START=2, N=3, M=4, C=5, BW=8, CP=9);
  - FSM state enum;
  - the cfg_entry_t struct {last, addr, data};
  - preset table constant.
- Sub-module pll_cfg_rom: registered lookup (preset, index) -> cfg_entry_t with 1-cycle latency.

Test Plan:
1. Reset, then cfg_req with sel=1 and no stalls. Required: writes (0,0), (5,0x00000202), (5,0x00040404), (2,1) in order; busy high throughout; locked raised 5 cycles after SETTLE gives done 1 cycle later, error=0.
2. waitrequest held for 3 cycles on the M write of preset 0. Required: address/data/write stable all 4 cycles; no duplicate write.
3. cfg_req pulsed during LOAD with sel=2. Required: ignored; sequence continues with the original preset; one done only.
4. pll_locked held 0. Required: done and error assert exactly LOCK_DLY+LOCK_TIMEOUT cycles after Start completes. A following request clears error at accept.
5. rst asserted during LOAD. Required: next cycle write=0, busy=0, no done; a later request runs normally from MODE.
6. PLL_CFG_READBACK_EN with readdata corrupted on C0 readback. Required: error=1, done pulse, no address-2 write.
